// File: rtl/spi_pwm_multi.sv
// N-channel PWM configured by pre-synchronised 32-bit command words.
// Duty and period writes land in shadow registers and reach the active
// registers only at a period boundary (or continuously while idle).
module spi_pwm_multi #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned CNT_W  = 30,
    parameter int unsigned DUTY_W = 24
) (
    input  logic              pwm_clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    input  logic [31:0]       cmd_data,
    output logic              cmd_err,
    output logic [31:0]       rd_data,
    output logic              period_tick,
    output logic [NUM_CH-1:0] pwm_out
);

    localparam logic [1:0] HDR_ENABLE = 2'b00;
    localparam logic [1:0] HDR_DUTY   = 2'b01;
    localparam logic [1:0] HDR_PERIOD = 2'b10;
    localparam logic [1:0] HDR_READ   = 2'b11;

    localparam logic [7:0] SEL_PER_ACT = 8'h80;
    localparam logic [7:0] SEL_PER_SH  = 8'h81;
    localparam logic [7:0] SEL_EN_MASK = 8'h82;

    logic [DUTY_W-1:0] duty_sh_q  [NUM_CH];
    logic [DUTY_W-1:0] duty_sh_d  [NUM_CH];
    logic [DUTY_W-1:0] duty_act_q [NUM_CH];
    logic [DUTY_W-1:0] duty_act_d [NUM_CH];
    logic [CNT_W-1:0]  per_sh_q, per_sh_d;
    logic [CNT_W-1:0]  per_act_q, per_act_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] en_mask_q, en_mask_d;
    logic [NUM_CH-1:0] pwm_out_q, pwm_out_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic              cmd_err_q, cmd_err_d;
    logic              period_tick_q, period_tick_d;

    logic [1:0]  hdr;
    logic [5:0]  ch;
    logic [7:0]  sel;
    logic [29:0] per_field;
    logic        per_hi_nz;
    logic        per_nz;
    logic        load;

    assign hdr       = cmd_data[31:30];
    assign ch        = cmd_data[29:24];
    assign sel       = cmd_data[7:0];
    assign per_field = cmd_data[29:0];
    // Period bits above the counter width must be zero for a legal write.
    assign per_hi_nz = (per_field >> CNT_W) != '0;
    assign per_nz    = per_act_q != '0;

    // Command decode: shadow/enable writes, readback mux and error pulse.
    always_comb begin
        en_mask_d = en_mask_q;
        per_sh_d  = per_sh_q;
        duty_sh_d = duty_sh_q;
        rd_data_d = rd_data_q;
        cmd_err_d = 1'b0;
        if (cmd_valid) begin
            unique case (hdr)
                HDR_ENABLE: en_mask_d = NUM_CH'(cmd_data);
                HDR_DUTY: begin
                    if (32'(ch) < NUM_CH) begin
                        for (int unsigned i = 0; i < NUM_CH; i++) begin
                            if (ch == 6'(i)) duty_sh_d[i] = DUTY_W'(cmd_data);
                        end
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                HDR_PERIOD: begin
                    if (per_hi_nz) cmd_err_d = 1'b1;
                    else           per_sh_d  = CNT_W'(cmd_data);
                end
                HDR_READ: begin
                    rd_data_d = '0;
                    if (32'(sel) < NUM_CH) begin
                        for (int unsigned i = 0; i < NUM_CH; i++) begin
                            if (sel == 8'(i)) rd_data_d = 32'(duty_act_q[i]);
                        end
                    end else if (sel == SEL_PER_ACT) begin
                        rd_data_d = 32'(per_act_q);
                    end else if (sel == SEL_PER_SH) begin
                        rd_data_d = 32'(per_sh_q);
                    end else if (sel == SEL_EN_MASK) begin
                        rd_data_d = 32'(en_mask_q);
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Period counter, shadow-to-active transfer and PWM compare.
    always_comb begin
        cnt_d      = cnt_q;
        per_act_d  = per_act_q;
        duty_act_d = duty_act_q;
        load       = 1'b0;
        if (!per_nz) begin
            cnt_d = '0;
            load  = 1'b1;
        end else if (cnt_q == per_act_q - CNT_W'(1)) begin
            cnt_d = '0;
            load  = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Loads use the pre-write shadow; a same-cycle write waits a period.
        if (load) begin
            per_act_d  = per_sh_q;
            duty_act_d = duty_sh_q;
        end
        period_tick_d = per_nz && (cnt_q == '0);
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pwm_out_d[i] = en_mask_q[i] && per_nz && (cnt_q < CNT_W'(duty_act_q[i]));
        end
    end

    // State registers; reset clears outputs asynchronously.
    always_ff @(posedge pwm_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                duty_sh_q[i]  <= '0;
                duty_act_q[i] <= '0;
            end
            per_sh_q      <= '0;
            per_act_q     <= '0;
            cnt_q         <= '0;
            en_mask_q     <= '0;
            pwm_out_q     <= '0;
            rd_data_q     <= '0;
            cmd_err_q     <= 1'b0;
            period_tick_q <= 1'b0;
        end else begin
            duty_sh_q     <= duty_sh_d;
            duty_act_q    <= duty_act_d;
            per_sh_q      <= per_sh_d;
            per_act_q     <= per_act_d;
            cnt_q         <= cnt_d;
            en_mask_q     <= en_mask_d;
            pwm_out_q     <= pwm_out_d;
            rd_data_q     <= rd_data_d;
            cmd_err_q     <= cmd_err_d;
            period_tick_q <= period_tick_d;
        end
    end

    assign cmd_err     = cmd_err_q;
    assign rd_data     = rd_data_q;
    assign period_tick = period_tick_q;
    assign pwm_out     = pwm_out_q;

endmodule

// File: tb/tb_spi_pwm_multi.sv
// Directed bench for spi_pwm_multi (3 channels, 28-bit counter).
module tb_spi_pwm_multi;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CNT_W  = 28;
    localparam int unsigned DUTY_W = 24;

    logic              pwm_clk;
    logic              reset_n;
    logic              cmd_valid;
    logic [31:0]       cmd_data;
    logic              cmd_err;
    logic [31:0]       rd_data;
    logic              period_tick;
    logic [NUM_CH-1:0] pwm_out;

    int checks = 0;
    int errors = 0;

    spi_pwm_multi #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .DUTY_W (DUTY_W)
    ) dut (
        .pwm_clk     (pwm_clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_data    (cmd_data),
        .cmd_err     (cmd_err),
        .rd_data     (rd_data),
        .period_tick (period_tick),
        .pwm_out     (pwm_out)
    );

    initial pwm_clk = 1'b0;
    always #5 pwm_clk = ~pwm_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One command strobe; returns on the negedge after it was captured.
    task automatic send(input logic [31:0] c);
        @(negedge pwm_clk);
        cmd_valid = 1'b1;
        cmd_data  = c;
        @(negedge pwm_clk);
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for a negedge where period_tick is high.
    task automatic wait_tick();
        bit found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge pwm_clk);
            if (period_tick) found = 1'b1;
        end
        if (!found) chk("tick_timeout", 32'd0, 32'd1);
    endtask

    // Check one 10-cycle period with ch1 low, ch2 high, ch0 width w0.
    // Optionally inject a command at sample inj_j (DUT cnt = inj_j+1).
    task automatic run_period(input int w0, input int inj_j, input logic [31:0] inj_cmd);
        logic [2:0] exp;
        wait_tick();
        for (int j = 0; j < 10; j++) begin
            if (j > 0) begin
                @(negedge pwm_clk);
                cmd_valid = 1'b0;
            end
            exp = {1'b1, 1'b0, (j < w0)};
            chk("pwm_period", 32'(pwm_out), 32'(exp));
            chk("tick_period", 32'(period_tick), 32'(j == 0));
            if (j == inj_j) begin
                cmd_valid = 1'b1;
                cmd_data  = inj_cmd;
            end
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        repeat (3) @(negedge pwm_clk);
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_rd", rd_data, 32'd0);
        chk("rst_err", 32'(cmd_err), 32'd0);
        chk("rst_tick", 32'(period_tick), 32'd0);
        reset_n = 1'b1;

        // Basic programming: period 10, duties 3/0/12, all enabled.
        send(32'h4000_0003);
        send(32'h4100_0000);
        send(32'h4200_000C);
        send(32'h0000_0007);
        send(32'h8000_000A);
        chk("per_ok_err", 32'(cmd_err), 32'd0);
        run_period(3, -1, 32'h0);
        run_period(3, -1, 32'h0);

        // Mid-period duty change applies at the next period.
        run_period(3, 4, 32'h4000_0007);
        // Duty write in the boundary cycle: old duty holds one more period.
        run_period(7, 8, 32'h4000_0002);
        run_period(7, -1, 32'h0);
        run_period(2, -1, 32'h0);

        // Rejected commands leave registers untouched.
        send(32'h4500_0001);
        chk("bad_ch_err", 32'(cmd_err), 32'd1);
        @(negedge pwm_clk);
        chk("bad_ch_err_low", 32'(cmd_err), 32'd0);
        send(32'hA000_0005);
        chk("bad_per_err", 32'(cmd_err), 32'd1);
        @(negedge pwm_clk);
        chk("bad_per_err_low", 32'(cmd_err), 32'd0);
        send(32'hC000_0081);
        chk("rd_per_sh", rd_data, 32'h0000_000A);
        chk("rd_ok_err", 32'(cmd_err), 32'd0);
        send(32'hC000_0000);
        chk("rd_duty0", rd_data, 32'h0000_0002);
        send(32'hC000_0001);
        chk("rd_duty1", rd_data, 32'h0000_0000);
        send(32'hC000_0002);
        chk("rd_duty2", rd_data, 32'h0000_000C);

        // Disable ch2 mid-period, then re-enable with mask 101.
        send(32'h0000_0003);
        chk("dis_ch2_prev", 32'(pwm_out[2]), 32'd1);
        @(negedge pwm_clk);
        chk("dis_ch2_low", 32'(pwm_out[2]), 32'd0);
        send(32'h0000_0005);
        @(negedge pwm_clk);
        chk("en_ch2_high", 32'(pwm_out[2]), 32'd1);

        // Readback selects.
        send(32'hC000_0080);
        chk("rd_per_act", rd_data, 32'h0000_000A);
        send(32'hC000_0082);
        chk("rd_en_mask", rd_data, 32'h0000_0005);
        @(negedge pwm_clk);
        chk("rd_hold", rd_data, 32'h0000_0005);
        send(32'hC000_0090);
        chk("rd_bad_sel", rd_data, 32'h0000_0000);
        chk("rd_bad_err", 32'(cmd_err), 32'd1);

        // Asynchronous reset with outputs high.
        wait_tick();
        chk("pre_rst_pwm", 32'(pwm_out), 32'h0000_0005);
        #2 reset_n = 1'b0;
        #1 chk("async_rst_pwm", 32'(pwm_out), 32'd0);
        chk("async_rst_rd", rd_data, 32'd0);
        repeat (3) @(negedge pwm_clk);
        reset_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge pwm_clk);
            chk("idle_pwm", 32'(pwm_out), 32'd0);
            chk("idle_tick", 32'(period_tick), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
